// File: rtl/exe_result_stage_pkg.sv
// Shared types and constants for the execute-stage sequencer.
//   OP_W        : one-hot ALU operation width (bits [18:12] are mul/div)
//   DATA_W      : operand / result / PC width
//   DEST_W      : register-index width
//   MULDIV_MASK : selects the multi-cycle mul/div operation bits
//   es_state_e  : sequencer states
package exe_result_stage_pkg;

  localparam int unsigned OP_W   = 19;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEST_W = 5;

  localparam logic [OP_W-1:0] MULDIV_MASK = 19'h7F000;

  typedef enum logic [1:0] {
    StIdle,   // empty
    StBusy,   // operation driven to the ALU
    StHold,   // result latched, waiting on the memory stage
    StDrain   // flushed while mul/div is still running
  } es_state_e;

endpackage

// File: rtl/exe_result_stage_if.sv
// Signal bundle between the execute stage and its surroundings (decode, ALU,
// memory stage, exception flush, forwarding network).
//   slave  : the execute stage's view
//   master : the environment's view (decode/ALU/memory stage)
interface exe_result_stage_if;
  import exe_result_stage_pkg::*;

  // decode -> execute
  logic              ds_to_es_valid;
  logic              es_allowin;
  logic [DATA_W-1:0] ds_pc;
  logic [OP_W-1:0]   ds_alu_op;
  logic [DATA_W-1:0] ds_alu_src1;
  logic [DATA_W-1:0] ds_alu_src2;
  logic [DEST_W-1:0] ds_dest;
  logic              ds_gr_we;
  logic              ds_res_from_mem;
  // execute <-> ALU
  logic [OP_W-1:0]   es_alu_op;
  logic [DATA_W-1:0] es_alu_src1;
  logic [DATA_W-1:0] es_alu_src2;
  logic              alu_complete;
  logic [DATA_W-1:0] alu_result;
  logic              res_from_mul;
  logic [DATA_W-1:0] mul_res;
  // execute -> memory
  logic              ms_allowin;
  logic              es_to_ms_valid;
  logic [DATA_W-1:0] es_pc;
  logic [DEST_W-1:0] es_dest;
  logic              es_gr_we;
  logic              es_res_from_mem;
  logic [DATA_W-1:0] es_result;
  // control / forwarding
  logic              flush;
  logic              es_fwd_valid;
  logic [DEST_W-1:0] es_fwd_dest;
  logic [DATA_W-1:0] es_fwd_data;
  logic              es_fwd_block;

  modport slave (
    input  ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest, ds_gr_we,
           ds_res_from_mem, alu_complete, alu_result, res_from_mul, mul_res, ms_allowin, flush,
    output es_allowin, es_alu_op, es_alu_src1, es_alu_src2, es_to_ms_valid, es_pc, es_dest,
           es_gr_we, es_res_from_mem, es_result, es_fwd_valid, es_fwd_dest, es_fwd_data,
           es_fwd_block
  );

  modport master (
    output ds_to_es_valid, ds_pc, ds_alu_op, ds_alu_src1, ds_alu_src2, ds_dest, ds_gr_we,
           ds_res_from_mem, alu_complete, alu_result, res_from_mul, mul_res, ms_allowin, flush,
    input  es_allowin, es_alu_op, es_alu_src1, es_alu_src2, es_to_ms_valid, es_pc, es_dest,
           es_gr_we, es_res_from_mem, es_result, es_fwd_valid, es_fwd_dest, es_fwd_data,
           es_fwd_block
  );

endinterface

// File: rtl/exe_fwd_sel.sv
// Combinational generator of the execute-stage forwarding/interlock outputs.
// Configuration macro: EXE_FWD_EN
//   defined   : real data forwarded; decode stalls only when data is not ready
//   undefined : data forced to 0; decode stalls on every destination match
// Ports:
//   i_busy/i_hold        : sequencer is in BUSY / HOLD
//   i_alu_complete       : ALU result valid this cycle
//   i_gr_we/i_res_from_mem/i_dest : registered instruction attributes
//   i_cur_res            : live ALU/multiplier result
//   i_latched_res        : result captured on back-pressure
//   o_fwd_valid/o_fwd_dest/o_fwd_data/o_fwd_block : forwarding outputs
module exe_fwd_sel
  import exe_result_stage_pkg::*;
(
  input  logic              i_busy,
  input  logic              i_hold,
  input  logic              i_alu_complete,
  input  logic              i_gr_we,
  input  logic              i_res_from_mem,
  input  logic [DEST_W-1:0] i_dest,
  input  logic [DATA_W-1:0] i_cur_res,
  input  logic [DATA_W-1:0] i_latched_res,
  output logic              o_fwd_valid,
  output logic [DEST_W-1:0] o_fwd_dest,
  output logic [DATA_W-1:0] o_fwd_data,
  output logic              o_fwd_block
);

  // Register 0 is hard-wired, so a write to it never needs forwarding.
  assign o_fwd_valid = (i_busy | i_hold) & i_gr_we & (i_dest != '0);
  assign o_fwd_dest  = i_dest;

`ifdef EXE_FWD_EN
  // Loads resolve in the memory stage; mul/div data exists only on completion.
  assign o_fwd_block = o_fwd_valid & (i_res_from_mem | (i_busy & ~i_alu_complete));

  always_comb begin
    o_fwd_data = '0;
    if (i_hold) begin
      o_fwd_data = i_latched_res;
    end else if (i_busy) begin
      o_fwd_data = i_cur_res;
    end
  end
`else
  assign o_fwd_block = o_fwd_valid;
  assign o_fwd_data  = '0;

  logic w_unused;
  assign w_unused = ^{i_alu_complete, i_res_from_mem, i_cur_res, i_latched_res};
`endif

endmodule

// File: rtl/exe_result_stage.sv
// Execute-stage sequencer: registers the decoded operation, drives the ALU,
// waits for multi-cycle mul/div completion, merges alu_result/mul_res and
// hands the result to the memory stage over valid/allowin. Also publishes
// forwarding/interlock information (see exe_fwd_sel; macro EXE_FWD_EN).
// Ports:
//   clk    : rising-edge clock
//   resetn : asynchronous active-low reset
//   es_bus : exe_result_stage_if.slave (decode, ALU, memory, flush, forwarding)
module exe_result_stage
  import exe_result_stage_pkg::*;
(
  input logic                 clk,
  input logic                 resetn,
  exe_result_stage_if.slave   es_bus
);

  es_state_e r_state, w_state_next;

  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;
  logic [DATA_W-1:0] r_pc;
  logic [DEST_W-1:0] r_dest;
  logic              r_gr_we;
  logic              r_res_from_mem;
  logic [DATA_W-1:0] r_result;

  logic              w_idle, w_busy, w_hold, w_drain;
  logic              w_allowin, w_acc, w_muldiv, w_latch;
  logic [DATA_W-1:0] w_cur_res;

  assign w_idle  = (r_state == StIdle);
  assign w_busy  = (r_state == StBusy);
  assign w_hold  = (r_state == StHold);
  assign w_drain = (r_state == StDrain);

  assign w_cur_res = es_bus.res_from_mul ? es_bus.mul_res : es_bus.alu_result;
  assign w_muldiv  = |(r_op & MULDIV_MASK);

  assign w_allowin = ~es_bus.flush &
                     (w_idle | (w_busy & es_bus.alu_complete & es_bus.ms_allowin) |
                      (w_hold & es_bus.ms_allowin));
  assign w_acc     = es_bus.ds_to_es_valid & w_allowin;
  // Capture the result only when it cannot be handed off this cycle.
  assign w_latch   = w_busy & es_bus.alu_complete & ~es_bus.ms_allowin & ~es_bus.flush;

  always_comb begin
    w_state_next = r_state;
    if (es_bus.flush) begin
      // A running mul/div cannot be aborted; let it finish in DRAIN.
      if ((w_busy & w_muldiv & ~es_bus.alu_complete) | (w_drain & ~es_bus.alu_complete)) begin
        w_state_next = StDrain;
      end else begin
        w_state_next = StIdle;
      end
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_acc) w_state_next = StBusy;
        end
        StBusy: begin
          if (es_bus.alu_complete) begin
            if (es_bus.ms_allowin) w_state_next = w_acc ? StBusy : StIdle;
            else                   w_state_next = StHold;
          end
        end
        StHold: begin
          if (es_bus.ms_allowin) w_state_next = w_acc ? StBusy : StIdle;
        end
        StDrain: begin
          if (es_bus.alu_complete) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state        <= StIdle;
      r_op           <= '0;
      r_src1         <= '0;
      r_src2         <= '0;
      r_pc           <= '0;
      r_dest         <= '0;
      r_gr_we        <= 1'b0;
      r_res_from_mem <= 1'b0;
      r_result       <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_acc) begin
        r_op           <= es_bus.ds_alu_op;
        r_src1         <= es_bus.ds_alu_src1;
        r_src2         <= es_bus.ds_alu_src2;
        r_pc           <= es_bus.ds_pc;
        r_dest         <= es_bus.ds_dest;
        r_gr_we        <= es_bus.ds_gr_we;
        r_res_from_mem <= es_bus.ds_res_from_mem;
      end
      if (w_latch) begin
        r_result <= w_cur_res;
      end
    end
  end

  assign es_bus.es_allowin      = w_allowin;
  // Op is masked outside BUSY/DRAIN so mul/div is not re-triggered.
  assign es_bus.es_alu_op       = (w_busy | w_drain) ? r_op : '0;
  assign es_bus.es_alu_src1     = r_src1;
  assign es_bus.es_alu_src2     = r_src2;
  assign es_bus.es_to_ms_valid  = ((w_busy & es_bus.alu_complete) | w_hold) & ~es_bus.flush;
  assign es_bus.es_pc           = r_pc;
  assign es_bus.es_dest         = r_dest;
  assign es_bus.es_gr_we        = r_gr_we;
  assign es_bus.es_res_from_mem = r_res_from_mem;
  assign es_bus.es_result       = w_busy ? w_cur_res : r_result;

  exe_fwd_sel u_fwd_sel (
    .i_busy         (w_busy),
    .i_hold         (w_hold),
    .i_alu_complete (es_bus.alu_complete),
    .i_gr_we        (r_gr_we),
    .i_res_from_mem (r_res_from_mem),
    .i_dest         (r_dest),
    .i_cur_res      (w_cur_res),
    .i_latched_res  (r_result),
    .o_fwd_valid    (es_bus.es_fwd_valid),
    .o_fwd_dest     (es_bus.es_fwd_dest),
    .o_fwd_data     (es_bus.es_fwd_data),
    .o_fwd_block    (es_bus.es_fwd_block)
  );

endmodule

// File: tb/tb_exe_result_stage.sv
// Self-checking bench for exe_result_stage: directed scenarios followed by
// random traffic. A behavioural model tracks the instruction occupying the
// stage; expected handoffs go into a scoreboard queue that a separate monitor
// drains whenever the DUT hands off.
module tb_exe_result_stage;
  import exe_result_stage_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  exe_result_stage_if bus ();

  exe_result_stage dut (
    .clk    (clk),
    .resetn (resetn),
    .es_bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  dest;
    logic        gr_we;
    logic        rfm;
    logic [31:0] res;
  } exp_t;

  exp_t sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Model of the instruction held by the stage
  bit   m_have  = 1'b0;  // live instruction present
  bit   m_done  = 1'b0;  // its result is computed and waiting
  bit   m_drain = 1'b0;  // a killed mul/div still running in the ALU
  int   m_cnt   = 0;     // ALU cycles still to go before completion
  int   m_op    = 0;
  exp_t m_cur;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [18:0] onehot(input int op);
    logic [18:0] r;
    r = '0;
    r[op] = 1'b1;
    return r;
  endfunction

  function automatic bit is_md(input int op);
    return op >= 12;
  endfunction

  function automatic logic [31:0] ref_res(input int op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      0:       return a + b;
      1:       return a - b;
      2:       return a & b;
      3:       return a | b;
      4:       return a ^ b;
      12:      return a * b;
      13:      return (b == 0) ? 32'h0 : a / b;
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: every handoff must match the oldest outstanding instruction.
  always @(negedge clk) begin
    if (resetn && bus.es_to_ms_valid && bus.ms_allowin) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_handoff: got pc 0x%0h, want no handoff", bus.es_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("handoff_pc", bus.es_pc, e.pc);
        chk("handoff_dest", 32'(bus.es_dest), 32'(e.dest));
        chk("handoff_gr_we", 32'(bus.es_gr_we), 32'(e.gr_we));
        chk("handoff_rfm", 32'(bus.es_res_from_mem), 32'(e.rfm));
        chk("handoff_result", bus.es_result, e.res);
      end
    end
  end

  // One clock cycle: drive inputs at posedge+1, check at posedge+2, advance model.
  task automatic cycle(input bit v, input int op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [4:0] dest, input bit we, input bit rfm, input bit msa,
                       input bit fl, input int lat);
    logic [31:0] pc;
    logic [31:0] r;
    bit cn, e_allow, e_valid, acc, fv, fb;
    logic [18:0] e_op;
    pc = $urandom;
    bus.ds_to_es_valid  = v;
    bus.ds_pc           = pc;
    bus.ds_alu_op       = onehot(op);
    bus.ds_alu_src1     = s1;
    bus.ds_alu_src2     = s2;
    bus.ds_dest         = dest;
    bus.ds_gr_we        = we;
    bus.ds_res_from_mem = rfm;
    bus.ms_allowin      = msa;
    bus.flush           = fl;

    // ALU model: computes from the operands the stage actually presents.
    cn = ((m_have && !m_done) || m_drain) && (m_cnt == 0);
    bus.alu_complete = cn;
    bus.alu_result   = $urandom;
    bus.mul_res      = $urandom;
    bus.res_from_mul = 1'($urandom_range(1));
    if (cn) begin
      r = ref_res(m_op, bus.es_alu_src1, bus.es_alu_src2);
      if (is_md(m_op)) begin
        bus.res_from_mul = 1'b1;
        bus.mul_res      = r;
      end else begin
        bus.res_from_mul = 1'b0;
        bus.alu_result   = r;
      end
    end
    #1;

    e_allow = !fl && !m_drain && (!m_have || ((cn || m_done) && msa));
    e_valid = m_have && (cn || m_done) && !fl;
    acc     = v && e_allow;
    e_op    = ((m_have && !m_done) || m_drain) ? onehot(m_op) : 19'h0;
    chk("es_allowin", 32'(bus.es_allowin), 32'(e_allow));
    chk("es_to_ms_valid", 32'(bus.es_to_ms_valid), 32'(e_valid));
    chk("es_alu_op", 32'(bus.es_alu_op), 32'(e_op));

    fv = m_have && m_cur.gr_we && (m_cur.dest != 0);
    chk("fwd_valid", 32'(bus.es_fwd_valid), 32'(fv));
    if (fv) chk("fwd_dest", 32'(bus.es_fwd_dest), 32'(m_cur.dest));
`ifdef EXE_FWD_EN
    fb = fv && (m_cur.rfm || (!m_done && !cn));
    if (fv && !fb) chk("fwd_data", bus.es_fwd_data, m_cur.res);
`else
    fb = fv;
    chk("fwd_data", bus.es_fwd_data, 32'h0);
`endif
    chk("fwd_block", 32'(bus.es_fwd_block), 32'(fb));

    @(posedge clk);
    if (fl) begin
      if ((m_have && !m_done && is_md(m_op) && !cn) || (m_drain && !cn)) begin
        m_drain = 1'b1;
        m_cnt--;
      end else begin
        m_drain = 1'b0;
      end
      if (m_have) begin
        m_have = 1'b0;
        m_done = 1'b0;
        void'(sb_q.pop_back());
      end
    end else begin
      if (m_drain) begin
        if (cn) m_drain = 1'b0;
        else    m_cnt--;
      end
      if (m_have) begin
        if (cn || m_done) begin
          if (msa) m_have = 1'b0;
          else     m_done = 1'b1;
        end else begin
          m_cnt--;
        end
      end
    end
    if (acc) begin
      m_have     = 1'b1;
      m_done     = 1'b0;
      m_op       = op;
      m_cnt      = is_md(op) ? lat : 0;
      m_cur.pc   = pc;
      m_cur.dest = dest;
      m_cur.gr_we = we;
      m_cur.rfm  = rfm;
      m_cur.res  = ref_res(op, s1, s2);
      sb_q.push_back(m_cur);
    end
    #1;
  endtask

  task automatic idle(input int n, input bit msa);
    for (int i = 0; i < n; i++) cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, msa, 1'b0, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_allowin"}, 32'(bus.es_allowin), 32'h1);
    chk({tag, "_valid"}, 32'(bus.es_to_ms_valid), 32'h0);
    chk({tag, "_alu_op"}, 32'(bus.es_alu_op), 32'h0);
    chk({tag, "_src1"}, bus.es_alu_src1, 32'h0);
    chk({tag, "_src2"}, bus.es_alu_src2, 32'h0);
    chk({tag, "_pc"}, bus.es_pc, 32'h0);
    chk({tag, "_dest"}, 32'(bus.es_dest), 32'h0);
    chk({tag, "_gr_we"}, 32'(bus.es_gr_we), 32'h0);
    chk({tag, "_rfm"}, 32'(bus.es_res_from_mem), 32'h0);
    chk({tag, "_result"}, bus.es_result, 32'h0);
    chk({tag, "_fwd_valid"}, 32'(bus.es_fwd_valid), 32'h0);
    chk({tag, "_fwd_block"}, 32'(bus.es_fwd_block), 32'h0);
    chk({tag, "_fwd_data"}, bus.es_fwd_data, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ops[7] = '{0, 1, 2, 3, 4, 12, 13};
    int guard;
    bus.ds_to_es_valid = 1'b0;  bus.ds_pc = '0;       bus.ds_alu_op = '0;
    bus.ds_alu_src1 = '0;       bus.ds_alu_src2 = '0; bus.ds_dest = '0;
    bus.ds_gr_we = 1'b0;        bus.ds_res_from_mem = 1'b0;
    bus.alu_complete = 1'b0;    bus.alu_result = '0;  bus.res_from_mul = 1'b0;
    bus.mul_res = '0;           bus.ms_allowin = 1'b1; bus.flush = 1'b0;

    #2;
    check_reset_outputs("reset");
    #10 resetn = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back ADDs, 5+7 then 9+1
    cycle(1'b1, 0, 32'h5, 32'h7, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b1, 0, 32'h9, 32'h1, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(2, 1'b1);

    // MUL 3*4 completing after three waiting cycles
    cycle(1'b1, 12, 32'h3, 32'h4, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 3);
    idle(5, 1'b1);

    // SUB 6-5 under 4 cycles of back-pressure
    cycle(1'b1, 1, 32'h6, 32'h5, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(4, 1'b0);
    idle(2, 1'b1);

    // DIV flushed on its second busy cycle; decode keeps offering during DRAIN
    cycle(1'b1, 13, 32'd100, 32'd7, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2, 32'hF0, 32'h3C, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(3, 1'b1);

    // Load to r5 (interlock), then ADD to r0 (no forwarding)
    cycle(1'b1, 0, 32'h1000, 32'h4, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    cycle(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    cycle(1'b1, 0, 32'h1, 32'h2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    idle(2, 1'b1);

    // Asynchronous reset while a MUL is busy
    cycle(1'b1, 12, 32'h11, 32'h22, 5'd10, 1'b1, 1'b0, 1'b1, 1'b0, 4);
    idle(1, 1'b1);
    bus.ds_to_es_valid = 1'b0;
    bus.alu_complete   = 1'b0;
    resetn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    if (m_have) void'(sb_q.pop_back());
    m_have = 1'b0;  m_done = 1'b0;  m_drain = 1'b0;
    @(posedge clk);
    #2 resetn = 1'b1;
    #1;
    chk("post_reset_allowin", 32'(bus.es_allowin), 32'h1);
    @(posedge clk);
    #1;
    idle(2, 1'b1);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      int op;
      logic [31:0] s2;
      op = ops[$urandom_range(6)];
      s2 = ($urandom_range(3) == 0) ? 32'($urandom_range(3)) : $urandom;
      cycle(($urandom_range(3) != 0), op, $urandom, s2,
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(3) != 0),
            ($urandom_range(15) == 0), $urandom_range(1, 4));
    end

    guard = 0;
    while ((m_have || m_drain) && guard < 20) begin
      idle(1, 1'b1);
      guard++;
    end
    idle(1, 1'b1);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
